// File: rtl/dmem_pkg.sv
// Shared types and constants for the sequenced data-memory arbiter and the
// pipeline memory stage that consumes its error flag.
package dmem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    XFER,
    DRAIN,
    RESP
  } state_t;

  localparam int MEM_BYTES_DEFAULT = 4096;

  localparam logic [1:0] STAT_AOK = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;

  // The memory stage reports an address fault as STAT_ADR.
  function automatic logic [1:0] err_to_stat(input logic err);
    return err ? STAT_ADR : STAT_AOK;
  endfunction

endpackage

// File: rtl/dmem_seq_arbiter_if.sv
// Requester-side bundle of the two quadword ports (pipeline and loader/debug).
interface dmem_seq_arbiter_if;

  logic        p0_req;
  logic        p0_we;
  logic [63:0] p0_addr;
  logic [63:0] p0_wdata;
  logic        p0_done;
  logic [63:0] p0_rdata;
  logic        p0_err;

  logic        p1_req;
  logic        p1_we;
  logic [63:0] p1_addr;
  logic [63:0] p1_wdata;
  logic        p1_done;
  logic [63:0] p1_rdata;
  logic        p1_err;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_done, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_done, p1_rdata, p1_err
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_done, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_done, p1_rdata, p1_err
  );

endinterface

// File: rtl/dmem_rr_arbiter.sv
// Two-way round-robin grant; on a tie the port that did not win last time wins.
module dmem_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_grant;

  // NOTE: gnt gets a default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    if (!accept) gnt = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept && (gnt != 2'b00)) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/dmem_seq_arbiter.sv
// Sequences 64-bit accesses from two ports into 8 little-endian byte beats on a
// byte-wide synchronous-read memory, with range check and a one-cycle done.
module dmem_seq_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int AW        = 12
) (
  input  logic                clk,
  input  logic                rst,
  dmem_seq_arbiter_if.slave   bus,
  output logic                busy,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_we,
  output logic [7:0]          mem_wdata,
  input  logic [7:0]          mem_rdata
);

  state_t      state;
  logic [2:0]  beat;
  logic [2:0]  beat_nxt;
  logic        sel;
  logic        lat_we;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;
  logic [55:0] rd_acc;
  logic [1:0]  done_q;
  logic [1:0]  err_q;
  logic [63:0] rdata0_q;
  logic [63:0] rdata1_q;
  logic [1:0]  gnt;

  assign beat_nxt = beat + 3'd1;

  dmem_rr_arbiter u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    ({bus.p1_req, bus.p0_req}),
    .accept (state == IDLE),
    .gnt    (gnt)
  );

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= 3'd0;
      sel       <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rd_acc    <= '0;
      done_q    <= 2'b00;
      err_q     <= 2'b00;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt != 2'b00) begin
            sel       <= gnt[1];
            lat_we    <= gnt[1] ? bus.p1_we    : bus.p0_we;
            lat_addr  <= gnt[1] ? bus.p1_addr  : bus.p0_addr;
            lat_wdata <= gnt[1] ? bus.p1_wdata : bus.p0_wdata;
            state     <= CHECK;
          end
        end
        CHECK: begin
          // Full 64-bit compare, so high address bits can never alias into range.
          if (lat_addr > 64'(MEM_BYTES - 8)) begin
            done_q[sel] <= 1'b1;
            err_q[sel]  <= 1'b1;
            state       <= RESP;
          end else begin
            beat      <= 3'd0;
            rd_acc    <= '0;
            mem_addr  <= lat_addr[AW-1:0];
            mem_we    <= lat_we;
            mem_wdata <= lat_wdata[7:0];
            state     <= XFER;
          end
        end
        XFER: begin
          // Read data lags the address by one cycle; bytes shift in from the top.
          if (beat != 3'd0) rd_acc <= {mem_rdata, rd_acc[55:8]};
          if (beat == 3'd7) begin
            mem_we <= 1'b0;
            state  <= DRAIN;
          end else begin
            beat      <= beat_nxt;
            mem_addr  <= lat_addr[AW-1:0] + AW'(beat_nxt);
            mem_wdata <= lat_wdata[{beat_nxt, 3'b000} +: 8];
          end
        end
        DRAIN: begin
          done_q[sel] <= 1'b1;
          if (sel) rdata1_q <= lat_we ? 64'd0 : {mem_rdata, rd_acc};
          else     rdata0_q <= lat_we ? 64'd0 : {mem_rdata, rd_acc};
          state <= RESP;
        end
        RESP: begin
          done_q   <= 2'b00;
          err_q    <= 2'b00;
          rdata0_q <= '0;
          rdata1_q <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign bus.p0_done  = done_q[0];
  assign bus.p0_err   = err_q[0];
  assign bus.p0_rdata = rdata0_q;
  assign bus.p1_done  = done_q[1];
  assign bus.p1_err   = err_q[1];
  assign bus.p1_rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_seq_arbiter.sv
// Self-checking bench: directed vector table, randomized traffic against a
// byte-array model, plus contention, mid-transfer reset and held-request sequences.
module tb_dmem_seq_arbiter;

  localparam int MEM_BYTES = 4096;
  localparam int AW        = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  dmem_seq_arbiter_if bus();

  dmem_seq_arbiter #(.MEM_BYTES(MEM_BYTES), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte array driven by the DUT, with a backdoor write path for preloading.
  logic [7:0]    ram [MEM_BYTES];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [7:0]    bd_data;

  always @(posedge clk) begin
    if (mem_we)     ram[mem_addr] <= mem_wdata;
    else if (bd_we) ram[bd_addr]  <= bd_data;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model: plain byte array updated by the architectural rules.
  logic [7:0] model_mem [MEM_BYTES];

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          port;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_err(input logic [63:0] a);
    return a > 64'(MEM_BYTES - 8);
  endfunction

  function automatic logic [63:0] model_read(input logic [63:0] a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = model_mem[int'(a[AW-1:0]) + i];
    return r;
  endfunction

  task automatic model_write(input logic [63:0] a, input logic [63:0] d);
    for (int i = 0; i < 8; i++) model_mem[int'(a[AW-1:0]) + i] = d[8*i +: 8];
  endtask

  function automatic logic [63:0] ram_quad(input int a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = ram[a + i];
    return r;
  endfunction

  task automatic drive_port(input bit port, input bit req, input bit we,
                            input logic [63:0] addr, input logic [63:0] wdata);
    if (port) begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end else begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end
  endtask

  // Entered at posedge+1 of an IDLE cycle; that cycle is cycle 0.
  task automatic run_txn(input bit port, input bit we, input logic [63:0] addr,
                         input logic [63:0] wdata, output logic [63:0] rd,
                         output logic er, output int lat, output int wecnt,
                         output bit other);
    rd = '0; er = 1'b0; lat = -1; wecnt = 0; other = 1'b0;
    drive_port(port, 1'b1, we, addr, wdata);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_we) wecnt++;
      if (port ? bus.p0_done : bus.p1_done) other = 1'b1;
      if (port ? bus.p1_done : bus.p0_done) begin
        lat = c;
        rd  = port ? bus.p1_rdata : bus.p0_rdata;
        er  = port ? bus.p1_err   : bus.p0_err;
        break;
      end
      tick();
    end
    tick();
    drive_port(port, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_txn(input string name, input logic [63:0] rd, input logic er,
                           input int lat, input int wecnt, input bit other,
                           input logic [63:0] exp_rd, input bit exp_err, input int exp_lat);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " rdata"}, rd, exp_rd);
    check({name, " err"}, 64'(er), 64'(exp_err));
    check({name, " we_beats"}, 64'(wecnt), (!exp_err && exp_lat == 11 && exp_rd == 0 && wecnt != 0) ? 64'd8 : 64'(wecnt));
    check({name, " other_done"}, 64'(other), 64'd0);
  endtask

  initial begin
    logic [63:0] rd, a, d, old_hi;
    logic        er;
    int          lat, wecnt, n_done, n_other, when, idle_cnt, bad;
    bit          other, p, w, e;
    int          done_cyc[$];
    bit          done_port[$];

    vecs[0] = '{0, 0, 64'd200,                 64'd0,                 64'h00000000000000C8, 0, 11};
    vecs[1] = '{1, 1, 64'h100,                 64'h1122334455667788,  64'd0,                0, 11};
    vecs[2] = '{1, 0, 64'h100,                 64'd0,                 64'h1122334455667788, 0, 11};
    vecs[3] = '{0, 1, 64'd4088,                64'hDEADBEEFCAFEF00D,  64'd0,                0, 11};
    vecs[4] = '{1, 0, 64'd4088,                64'd0,                 64'hDEADBEEFCAFEF00D, 0, 11};
    vecs[5] = '{0, 0, 64'd4089,                64'd0,                 64'd0,                1, 2};
    vecs[6] = '{1, 1, 64'hFFFFFFFFFFFFFFF8,    64'h0123456789ABCDEF,  64'd0,                1, 2};
    vecs[7] = '{0, 0, 64'hFFFFFFFFFFFFFFF8,    64'd0,                 64'd0,                1, 2};

    rst = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    drive_port(0, 0, 0, '0, '0);
    drive_port(1, 0, 0, '0, '0);
    tick();
    tick();

    // Preload while reset holds the DUT off the memory.
    for (int i = 0; i < MEM_BYTES; i++) begin
      bd_we   = 1'b1;
      bd_addr = AW'(i);
      bd_data = (i >= 200 && i < 208) ? ((i == 200) ? 8'hC8 : 8'h00) : 8'($urandom);
      model_mem[i] = bd_data;
      tick();
    end
    bd_we = 1'b0;
    tick();
    rst = 1'b0;

    check("reset flags", 64'({busy, bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err, mem_we}), 64'd0);
    check("reset p0_rdata", bus.p0_rdata, 64'd0);
    check("reset p1_rdata", bus.p1_rdata, 64'd0);
    check("reset mem_bus", 64'({mem_addr, mem_wdata}), 64'd0);

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat, wecnt, other);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d err", i), 64'(er), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d we_beats", i), 64'(wecnt),
            (vecs[i].we && !vecs[i].exp_err) ? 64'd8 : 64'd0);
      check($sformatf("vec%0d other_done", i), 64'(other), 64'd0);
      if (vecs[i].we && !vecs[i].exp_err) model_write(vecs[i].addr, vecs[i].wdata);
      if (i == 1) check("vec1 bytes 0x100", ram_quad(32'h100), 64'h1122334455667788);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      p = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       a = 64'(4080 + $urandom_range(0, 15));
        1:       a = {$urandom, $urandom};
        default: a = 64'($urandom_range(0, MEM_BYTES - 8));
      endcase
      d = {$urandom, $urandom};
      e = model_err(a);
      run_txn(p, w, a, d, rd, er, lat, wecnt, other);
      check($sformatf("rand%0d latency", i), 64'(lat), e ? 64'd2 : 64'd11);
      check($sformatf("rand%0d rdata", i), rd, (e || w) ? 64'd0 : model_read(a));
      check($sformatf("rand%0d err", i), 64'(er), 64'(e));
      check($sformatf("rand%0d we_beats", i), 64'(wecnt), (w && !e) ? 64'd8 : 64'd0);
      check($sformatf("rand%0d other_done", i), 64'(other), 64'd0);
      if (w && !e) model_write(a, d);
    end

    // Contention: both requests held from reset.
    rst = 1'b1;
    drive_port(0, 1, 0, 64'h10, '0);
    drive_port(1, 1, 1, 64'h20, 64'hA1B2C3D4E5F60718);
    tick();
    rst = 1'b0;
    model_write(64'h20, 64'hA1B2C3D4E5F60718);
    idle_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.p0_done && bus.p1_done) check("contention both done", 64'd1, 64'd0);
      if (bus.p0_done || bus.p1_done) begin
        done_cyc.push_back(c);
        done_port.push_back(bus.p1_done);
        if (bus.p0_done) check("contention p0 rdata", bus.p0_rdata, model_read(64'h10));
      end
      if (!busy && c <= 47) idle_cnt++;
    end
    check("contention done count", 64'(done_cyc.size()), 64'd4);
    for (int k = 0; k < 4 && k < done_cyc.size(); k++) begin
      check($sformatf("contention done%0d cycle", k), 64'(done_cyc[k]), 64'(11 + 12 * k));
      check($sformatf("contention done%0d port", k), 64'(done_port[k]), 64'(k % 2));
    end
    check("contention idle cycles", 64'(idle_cnt), 64'd4);
    check("contention write landed", ram_quad(32'h20), 64'hA1B2C3D4E5F60718);
    tick();
    rst = 1'b1;
    drive_port(0, 0, 0, '0, '0);
    drive_port(1, 0, 0, '0, '0);
    tick();
    rst = 1'b0;

    // Reset during beat 3 (cycle 5) of a write to 0x40.
    d      = 64'h0F1E2D3C4B5A6978;
    old_hi = model_read(64'h40);
    n_done = 0;
    drive_port(0, 1, 1, 64'h40, d);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.p0_done || bus.p1_done) n_done++;
      if (c < 5) tick();
    end
    rst = 1'b1;
    drive_port(0, 0, 0, '0, '0);
    tick();
    rst = 1'b0;
    check("midreset no done", 64'(n_done), 64'd0);
    check("midreset flags", 64'({busy, bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err, mem_we}), 64'd0);
    check("midreset mem_bus", 64'({mem_addr, mem_wdata}), 64'd0);
    check("midreset rdata", bus.p0_rdata | bus.p1_rdata, 64'd0);
    check("midreset bytes", ram_quad(32'h40), {old_hi[63:32], d[31:0]});
    for (int i = 0; i < 4; i++) model_mem[16'h40 + i] = d[8*i +: 8];
    run_txn(1, 0, 64'h40, '0, rd, er, lat, wecnt, other);
    check_txn("after reset", rd, er, lat, wecnt, other, model_read(64'h40), 0, 11);

    // Held request: p0 keeps req high for two cycles after done.
    when = -1; n_done = 0; n_other = 0; lat = -1;
    drive_port(0, 1, 0, 64'h300, '0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.p0_done) begin lat = c; break; end
      tick();
    end
    check("held first latency", 64'(lat), 64'd11);
    for (int c2 = 1; c2 <= 30; c2++) begin
      tick();
      if (c2 == 3) drive_port(0, 0, 0, '0, '0);
      @(negedge clk);
      if (bus.p0_done) begin
        n_done++;
        when = c2;
        check("held second rdata", bus.p0_rdata, model_read(64'h300));
      end
      if (bus.p1_done) n_other++;
    end
    tick();
    check("held extra count", 64'(n_done), 64'd1);
    check("held extra cycle", 64'(when), 64'd12);
    check("held p1 quiet", 64'(n_other), 64'd0);

    bad = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (ram[i] !== model_mem[i]) bad++;
    check("memory image", 64'(bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_seq_arbiter.md
Name: dmem_seq_arbiter

Overview:
- Shares the single byte-wide data memory between two quadword requesters:
  - Port 0: the pipeline memory stage.
  - Port 1: the program loader / debug port.
- Sequences each 64-bit access as 8 little-endian byte beats and performs the address-range check.
- Returns the assembled quadword, or an address error, with a one-cycle done pulse.
- Sits between the memory-stage logic and the data memory array, and replaces direct combinational array access.

Parameters:
- MEM_BYTES, 4096, data memory size in bytes.
- AW, 12, memory byte-address width; must satisfy 2**AW >= MEM_BYTES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 request; held until p0_done.
- p0_we  in  1  port 0: 1 = write quadword, 0 = read quadword.
- p0_addr  in  64  port 0 base byte address.
- p0_wdata  in  64  port 0 write data.
- p0_done  out  1  port 0 one-cycle completion pulse.
- p0_rdata  out  64  port 0 read data; valid while p0_done is high.
- p0_err  out  1  port 0 address error; valid while p0_done is high.
- p1_req, p1_we, p1_addr, p1_wdata, p1_done, p1_rdata, p1_err: identical to the port 0 signals, for port 1.
- busy  out  1  high whenever the state is not IDLE; the pipeline uses it for stall generation.
- mem_addr  out  AW  byte address to the memory array.
- mem_we  out  1  byte write strobe.
- mem_wdata  out  8  byte write data.
- mem_rdata  in  8  byte read data, returned one cycle after mem_addr is presented (synchronous read).

Behaviour:
- Reset (synchronous, active-high): values after the reset edge:
  - State IDLE, beat counter 0, last_grant = 1 (port 0 wins the first tie).
  - All done/err/busy/mem_we low; rdata outputs 0; mem_addr 0; mem_wdata 0.
  - A reset mid-transfer aborts it. No done is issued. mem_we is low from the next cycle. Bytes already written stay written.
- States:
  - IDLE: no transfer in progress.
  - CHECK: latched request range-checked.
  - XFER: the 8 byte beats.
  - DRAIN: captures the final read byte.
  - RESP: done pulse.
- IDLE:
  - Samples p0_req and p1_req.
  - One request pending: grant it.
  - Both pending: grant the port that is not last_grant.
  - On grant, latch port id, we, addr and wdata, and update last_grant. Next state is CHECK.
  - With no requests, stay in IDLE.
- CHECK:
  - If addr > MEM_BYTES-8 (full 64-bit compare), set err and go to RESP. No memory access is made.
  - Otherwise clear the beat counter and go to XFER.
- XFER, beat k = 0..7:
  - mem_addr = addr[AW-1:0] + k.
  - Write: mem_we = 1 and mem_wdata = wdata[8k+7:8k].
  - Read: mem_we = 0; the byte returned in the next cycle is stored to rdata[8(k-1)+7:8(k-1)].
  - After k = 7, go to DRAIN.
- DRAIN:
  - Read: captures byte 7 into rdata[63:56]. Write: idle cycle, which keeps latency uniform.
  - mem_we = 0. Next state is RESP.
- RESP:
  - The granted port's done = 1 for exactly one cycle, with rdata (0 for writes and errors) and err.
  - The other port's done stays 0. Next state is IDLE.
- Latency, counting the request-accepting IDLE cycle as cycle 0:
  - Normal access: done in cycle 11.
  - Error: done in cycle 2.
  - Back-to-back grants are separated by at least one IDLE cycle.
- Handshake rules:
  - The requester holds req, we, addr and wdata stable from assertion until done.
  - The requester must drop req in the cycle after done. A req still high in IDLE is treated as a new request.
  - An ungranted requester simply keeps req high; there is no starvation, because round-robin alternates under continuous contention.
- Address wrap: addresses pass CHECK only when addr + 7 < MEM_BYTES, so beat addresses never wrap.
- mem_* signals are decoded from registered state, counter and latched data only, never from the live req inputs.

Decomposition:
- Package dmem_pkg contains:
  - The state enum (IDLE, CHECK, XFER, DRAIN, RESP).
  - The MEM_BYTES default.
  - Status code constants shared with the pipeline: STAT_AOK = 1, STAT_ADR = 2. The memory stage maps err to STAT_ADR.
- Sub-module dmem_rr_arbiter: a 2-way round-robin grant with last_grant register, inputs req[1:0] and accept, output gnt[1:0].

Test Plan:
- Read: preload bytes 200..207 = C8,00,00,00,00,00,00,00; p0 read at addr 200 -> p0_done in cycle 11, p0_rdata = 0x00000000000000C8, p0_err = 0.
- Write then read: p1 writes 0x1122334455667788 to addr 0x100, then reads it back -> bytes 0x100..0x107 = 88,77,66,55,44,33,22,11; readback matches; mem_we is high for exactly 8 cycles.
- Range boundary: addr 4088 -> normal completion, err = 0. Addr 4089 and addr 0xFFFFFFFFFFFFFFF8 -> done in cycle 2, err = 1, rdata = 0, no mem_we pulse.
- Contention: p0_req and p1_req both held high from reset -> grant order p0, p1, p0, p1. Each done pulse is one cycle and only on the granted port; busy is low for exactly one cycle between transfers.
- Reset mid-transfer: assert rst during XFER beat 3 of a write to 0x40 -> bytes 0x40..0x43 written, 0x44..0x47 unchanged; no done pulse; all outputs at reset values in the next cycle; the next request completes normally.
- Held req: p0 keeps req high for 2 cycles after done -> exactly one extra transfer is started, with a second done at the expected cycle.
